polyphase_decim_fir: RTL and testbench
======================================

Name: polyphase_decim_fir

Overview:
- Parametrised polyphase decimating FIR; successor to the fixed 4-phase, 11-bit direct polyphase convolver.
- Decimates by PHASES, with TAPS coefficients per phase (N = PHASES*TAPS total), all runtime-loadable.
- Per-phase multipliers are time-multiplexed over TAPS cycles, with a valid/ready input handshake and a valid-qualified output.
- Sits between the ADC sample front end and the downstream PP processing chain.

Parameters:
- DATA_W, 11: signed input sample width.
- COEF_W, 11: signed coefficient width.
- PHASES, 4: decimation factor and number of parallel multipliers; must be >= 2.
- TAPS, 4: taps per phase; must be >= 1.
- ACC_W, 48: accumulator and full-precision output width; must be >= DATA_W+COEF_W+clog2(N).
- OUT_W, 16: output width, used only with ROUND_SAT_EN.
- FRAC_SHIFT, 10: right shift before rounding, used only with ROUND_SAT_EN.

Ports:
- sys_clk_i  in  1  sole clock, rising edge.
- sys_rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  resync pulse: clears delay line and phase counter, aborts any computation.
- din_valid_i  in  1  input sample valid.
- din_i  in  DATA_W  signed input sample.
- din_ready_o  out  1  sample accepted on an edge where din_valid_i & din_ready_o.
- coef_we_i  in  1  coefficient write strobe.
- coef_addr_i  in  clog2(N)  coefficient index k, 0..N-1.
- coef_data_i  in  COEF_W  signed coefficient h[k].
- busy_o  out  1  MAC in progress.
- dout_valid_o  out  1  one-cycle output strobe.
- dout_o  out  ACC_W (OUT_W with ROUND_SAT_EN)  signed decimated output.

Behaviour:
- Reset (async):
  - Delay line, coefficients, phase counter, accumulator and tap counter all 0.
  - State IDLE.
  - dout_o=0, dout_valid_o=0, busy_o=0, din_ready_o=1.
- Delay line:
  - N-entry shift register, x[0] newest.
  - On each accepted sample: x[k]<=x[k-1], x[0]<=din_i.
  - The phase counter cnt counts accepted samples 0..PHASES-1 and wraps.
- Launch (edge E0):
  - Occurs when a sample is accepted with cnt==PHASES-1.
  - The snapshot buffer takes the post-shift delay line (including the new sample).
  - State goes to MAC, tap counter t<=0, acc<=0.
- MAC state (edges E1..E_TAPS):
  - Each edge: acc <= acc + sum over p=0..PHASES-1 of h[t*PHASES+p]*snap[t*PHASES+p]; t<=t+1.
  - Products are DATA_W+COEF_W signed, sign-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W.
- Output:
  - On the edge with t==TAPS-1: dout_o <= final sum, dout_valid_o<=1 for exactly one cycle, state goes to IDLE.
  - Latency: dout_valid_o is high in the cycle after edge E_TAPS.
  - dout_o holds its value until the next result.
  - Result: y = sum over k=0..N-1 of h[k]*x[k] at launch.
- busy_o: 1 while state==MAC.
- din_ready_o = !(busy_o && cnt==PHASES-1).
  - A new launch never overlaps a computation.
  - Non-launching samples are always accepted, including during MAC.
- Coefficient writes:
  - coef_we_i with coef_addr_i<N writes h[addr] on that edge.
  - Addresses >= N are ignored.
  - Writes while busy_o=1 are dropped; the result in flight uses unchanged coefficients.
- start_i:
  - Synchronous.
  - Clears delay line, snapshot and cnt; state goes to IDLE; any pending output is suppressed (no dout_valid_o).
  - Coefficients and dout_o are preserved.
  - If din_valid_i is high in the same cycle, that sample is accepted as the first sample of the fresh line (x[0]=din_i, cnt=1).
- Reset mid-MAC: immediate return to the reset state; no output strobe.

Optional Feature:
- Macro: POLYPHASE_DECIM_FIR_ROUND_SAT_EN.
- Defined:
  - dout_o is OUT_W bits.
  - dout_o = saturate(round_half_up(acc >>> FRAC_SHIFT)) to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Rounding adds 2^(FRAC_SHIFT-1) before the shift.
  - Rounding/saturation is combined into the output register; latency is unchanged.
- Undefined: dout_o is the raw ACC_W accumulator value; the OUT_W and FRAC_SHIFT parameters are unused.

Test Plan:
- Reset: assert sys_rst_i mid-run -> dout_o=0, dout_valid_o=0, busy_o=0, din_ready_o=1 immediately, without waiting for a clock edge.
- Impulse: h[k]=k+1 (k=0..15), stream 1 followed by zeros, valid every cycle -> successive outputs 4, 8, 12, 16, then 0; each dout_valid_o arrives 4 edges after its launch edge.
- DC plus backpressure: all h=1, x=1 continuous -> outputs 4, 8, 12, 16, 16, ...
  - din_ready_o drops for exactly one cycle on each launch sample after the first.
  - No samples lost (output count = accepted/4).
- Extremes: all h=-1024, x=-1024 for >=16 samples -> steady output 16777216 (0x1000000).
- Coefficient and resync edge cases:
  - A coef write during busy_o is dropped: readback via impulse response is unchanged.
  - An out-of-range address is ignored.
  - start_i during MAC -> no dout_valid_o; next output only after 4 fresh samples.
- ROUND_SAT_EN (OUT_W=16, FRAC_SHIFT=8):
  - The extremes case yields 32767 (saturated).
  - Acc=384 yields 2 (round half up).

Source files
------------

// File: rtl/polyphase_decim_fir.sv
// Polyphase decimating FIR: PHASES parallel multipliers time-shared over TAPS cycles per output.
// Optional rounding/saturating output stage enabled by POLYPHASE_DECIM_FIR_ROUND_SAT_EN.
module polyphase_decim_fir #(
    parameter int DATA_W     = 11,
    parameter int COEF_W     = 11,
    parameter int PHASES     = 4,
    parameter int TAPS       = 4,
    parameter int ACC_W      = 48,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 10
) (
    input  logic                              sys_clk_i,
    input  logic                              sys_rst_i,
    input  logic                              start_i,
    input  logic                              din_valid_i,
    input  logic signed [DATA_W-1:0]          din_i,
    output logic                              din_ready_o,
    input  logic                              coef_we_i,
    input  logic [$clog2(PHASES*TAPS)-1:0]    coef_addr_i,
    input  logic signed [COEF_W-1:0]          coef_data_i,
    output logic                              busy_o,
    output logic                              dout_valid_o,
`ifdef POLYPHASE_DECIM_FIR_ROUND_SAT_EN
    output logic signed [OUT_W-1:0]           dout_o
`else
    output logic signed [ACC_W-1:0]           dout_o
`endif
);

    localparam int N      = PHASES * TAPS;
    localparam int ADDR_W = $clog2(N);
    localparam int CNT_W  = $clog2(PHASES);
    localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;

    if (PHASES < 2) begin : g_bad_phases
        $error("PHASES must be at least 2");
    end
    if (TAPS < 1) begin : g_bad_taps
        $error("TAPS must be at least 1");
    end
    if (ACC_W < PROD_W + ADDR_W) begin : g_bad_acc
        $error("ACC_W too narrow for full-precision accumulation");
    end
    if (OUT_W < 2 || FRAC_SHIFT < 1) begin : g_bad_fmt
        $error("OUT_W must be >= 2 and FRAC_SHIFT >= 1");
    end

    typedef enum logic {
        IDLE,
        MAC
    } state_t;

    state_t state, state_next;

    logic signed [DATA_W-1:0] x_line [N];
    logic signed [DATA_W-1:0] snap   [N];
    logic signed [COEF_W-1:0] coef   [N];

    logic [CNT_W-1:0]         cnt;
    logic [TAP_W-1:0]         tap_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  partial;
    logic signed [ACC_W-1:0]  sum_next;
    logic [ADDR_W-1:0]        idx;
    logic signed [PROD_W-1:0] prod;

    logic cnt_wrap;
    logic accept;
    logic launch;
    logic last_tap;
    logic addr_ok;

    assign busy_o      = (state == MAC);
    assign cnt_wrap    = (cnt == CNT_W'(PHASES - 1));
    assign din_ready_o = !(busy_o && cnt_wrap);
    assign accept      = din_valid_i && din_ready_o;
    assign launch      = accept && cnt_wrap && !start_i;
    assign last_tap    = busy_o && (tap_cnt == TAP_W'(TAPS - 1));

    // A power-of-two N makes every address legal, so no compare is elaborated.
    if (N == (1 << ADDR_W)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (coef_addr_i < ADDR_W'(N));
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            for (int k = 0; k < N; k++) begin
                coef[k] <= '0;
            end
        end else if (coef_we_i && !busy_o && addr_ok) begin
            coef[coef_addr_i] <= coef_data_i;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            for (int k = 0; k < N; k++) begin
                x_line[k] <= '0;
                snap[k]   <= '0;
            end
            cnt <= '0;
        end else if (start_i) begin
            for (int k = 0; k < N; k++) begin
                x_line[k] <= '0;
                snap[k]   <= '0;
            end
            cnt <= '0;
            if (accept) begin
                x_line[0] <= din_i;
                cnt       <= CNT_W'(1);
            end
        end else if (accept) begin
            x_line[0] <= din_i;
            for (int k = 1; k < N; k++) begin
                x_line[k] <= x_line[k-1];
            end
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            // The snapshot sees the line as it will be after this shift.
            if (cnt_wrap) begin
                snap[0] <= din_i;
                for (int k = 1; k < N; k++) begin
                    snap[k] <= x_line[k-1];
                end
            end
        end
    end

    always_comb begin
        partial = '0;
        idx     = '0;
        prod    = '0;
        for (int p = 0; p < PHASES; p++) begin
            idx     = ADDR_W'(int'(tap_cnt) * PHASES + p);
            prod    = PROD_W'(snap[idx]) * PROD_W'(coef[idx]);
            partial = partial + ACC_W'(prod);
        end
    end

    assign sum_next = acc + partial;

`ifdef POLYPHASE_DECIM_FIR_ROUND_SAT_EN
    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_W:0] OUT_MAX  = (ACC_W + 1)'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN  = -OUT_MAX - 1;

    function automatic logic signed [OUT_W-1:0] format_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] r;
        r = ((ACC_W + 1)'(v) + RND_HALF) >>> FRAC_SHIFT;
        if (r > OUT_MAX) begin
            return OUT_W'(OUT_MAX);
        end else if (r < OUT_MIN) begin
            return OUT_W'(OUT_MIN);
        end
        return OUT_W'(r);
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] format_out(input logic signed [ACC_W-1:0] v);
        return v;
    endfunction
`endif

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (launch)   state_next = MAC;
                MAC:     if (last_tap) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // start_i wins over the final MAC edge so an aborted result never strobes out.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            acc          <= '0;
            tap_cnt      <= '0;
            dout_o       <= '0;
            dout_valid_o <= 1'b0;
        end else begin
            dout_valid_o <= 1'b0;
            if (start_i || launch) begin
                acc     <= '0;
                tap_cnt <= '0;
            end else if (busy_o) begin
                acc     <= sum_next;
                tap_cnt <= tap_cnt + 1'b1;
                if (last_tap) begin
                    dout_o       <= format_out(sum_next);
                    dout_valid_o <= 1'b1;
                    tap_cnt      <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_polyphase_decim_fir.sv
// Directed bench for polyphase_decim_fir: reset, impulse, DC with backpressure, extremes,
// coefficient-write and resync corner cases; also covers POLYPHASE_DECIM_FIR_ROUND_SAT_EN.
module tb_polyphase_decim_fir;

    localparam int DATA_W     = 11;
    localparam int COEF_W     = 11;
    localparam int PHASES     = 4;
    localparam int TAPS       = 4;
    localparam int ACC_W      = 48;
    localparam int OUT_W      = 16;
    localparam int FRAC_SHIFT = 8;
    localparam int N          = PHASES * TAPS;
`ifdef POLYPHASE_DECIM_FIR_ROUND_SAT_EN
    localparam int DOUT_W = OUT_W;
`else
    localparam int DOUT_W = ACC_W;
`endif

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     din_valid;
    logic signed [DATA_W-1:0] din;
    logic                     din_ready;
    logic                     coef_we;
    logic [$clog2(N)-1:0]     coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     busy;
    logic                     dout_valid;
    logic signed [DOUT_W-1:0] dout;

    int n_compared = 0;
    int n_failed   = 0;
    int cyc        = 0;
    int stall_cnt  = 0;

    logic signed [DOUT_W-1:0] out_val_q [$];
    int                       out_cyc_q [$];

    polyphase_decim_fir #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .PHASES    (PHASES),
        .TAPS      (TAPS),
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .start_i     (start),
        .din_valid_i (din_valid),
        .din_i       (din),
        .din_ready_o (din_ready),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .busy_o      (busy),
        .dout_valid_o(dout_valid),
        .dout_o      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            out_val_q.push_back(dout);
            out_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected output word for a raw full-precision sum.
    function automatic logic signed [DOUT_W-1:0] exp_out(input longint raw);
`ifdef POLYPHASE_DECIM_FIR_ROUND_SAT_EN
        longint r;
        r = (raw + (longint'(1) << (FRAC_SHIFT - 1))) >>> FRAC_SHIFT;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return DOUT_W'(r);
`else
        return DOUT_W'(raw);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_outputs();
        out_val_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_outputs();
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = COEF_W'(d);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic push_sample(input int v);
        int waited;
        waited    = 0;
        din_valid = 1'b1;
        din       = DATA_W'(v);
        while (din_ready !== 1'b1 && waited < 20) begin
            stall_cnt++;
            waited++;
            tick();
        end
        if (waited >= 20) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL push_timeout: got din_ready low for %0d cycles, expected acceptance", waited);
        end
        tick();
    endtask

    task automatic wait_outputs(input int n, input int budget);
        int k;
        k = 0;
        while (out_val_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (out_val_q.size() < n) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL wait_outputs: got %0d results, expected %0d", out_val_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        #2;
        n_compared++; if (dout !== '0) begin n_failed++; $display("[TB] FAIL rst0_dout: got %0d, expected 0", dout); end
        n_compared++; if (dout_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL rst0_valid: got %b, expected 0", dout_valid); end
        n_compared++; if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL rst0_busy: got %b, expected 0", busy); end
        n_compared++; if (din_ready !== 1'b1) begin n_failed++; $display("[TB] FAIL rst0_ready: got %b, expected 1", din_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) write_coef(k, 1);
        clear_outputs();
        repeat (8) push_sample(1);
        din_valid = 1'b0;
        #2;
        n_compared++; if (out_val_q.size() != 1 || out_val_q[0] !== exp_out(4)) begin n_failed++; $display("[TB] FAIL midrun_first: got %0d results, expected one of value 4", out_val_q.size()); end
        n_compared++; if (busy !== 1'b1) begin n_failed++; $display("[TB] FAIL midrun_busy: got %b, expected 1", busy); end
        rst = 1'b1;
        #1;
        n_compared++; if (dout !== '0) begin n_failed++; $display("[TB] FAIL rst1_dout: got %0d, expected 0", dout); end
        n_compared++; if (dout_valid !== 1'b0) begin n_failed++; $display("[TB] FAIL rst1_valid: got %b, expected 0", dout_valid); end
        n_compared++; if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL rst1_busy: got %b, expected 0", busy); end
        n_compared++; if (din_ready !== 1'b1) begin n_failed++; $display("[TB] FAIL rst1_ready: got %b, expected 1", din_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_outputs();
        idle(8);
        n_compared++; if (out_val_q.size() != 0) begin n_failed++; $display("[TB] FAIL rst1_nostrobe: got %0d results, expected 0", out_val_q.size()); end
    endtask

    task automatic test_impulse();
        int launch_cyc;
        int exp_imp [5];
        exp_imp = '{4, 8, 12, 16, 0};
        launch_cyc = 0;
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        clear_outputs();
        push_sample(1);
        for (int i = 1; i < 20; i++) begin
            push_sample(0);
            if (i == 3) launch_cyc = cyc;
        end
        idle(1);
        wait_outputs(5, 40);
        for (int i = 0; i < 5; i++) begin
            n_compared++;
            if (out_val_q[i] !== exp_out(exp_imp[i])) begin
                n_failed++;
                $display("[TB] FAIL impulse_out%0d: got %0d, expected %0d", i, out_val_q[i], exp_out(exp_imp[i]));
            end
        end
        n_compared++; if (out_cyc_q[0] - launch_cyc != 4) begin n_failed++; $display("[TB] FAIL impulse_latency: got %0d edges, expected 4", out_cyc_q[0] - launch_cyc); end
        idle(10);
        n_compared++; if (out_val_q.size() != 5) begin n_failed++; $display("[TB] FAIL impulse_count: got %0d, expected 5", out_val_q.size()); end
    endtask

    task automatic test_dc_backpressure();
        int exp_dc [6];
        exp_dc = '{4, 8, 12, 16, 16, 16};
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, 1);
        clear_outputs();
        stall_cnt = 0;
        repeat (24) push_sample(1);
        idle(1);
        wait_outputs(6, 40);
        for (int i = 0; i < 6; i++) begin
            n_compared++;
            if (out_val_q[i] !== exp_out(exp_dc[i])) begin
                n_failed++;
                $display("[TB] FAIL dc_out%0d: got %0d, expected %0d", i, out_val_q[i], exp_out(exp_dc[i]));
            end
        end
        n_compared++; if (stall_cnt != 5) begin n_failed++; $display("[TB] FAIL dc_stalls: got %0d, expected 5", stall_cnt); end
        idle(10);
        n_compared++; if (out_val_q.size() != 6) begin n_failed++; $display("[TB] FAIL dc_count: got %0d, expected 6", out_val_q.size()); end
    endtask

    task automatic test_extremes();
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, -1024);
        clear_outputs();
        repeat (20) push_sample(-1024);
        idle(1);
        wait_outputs(5, 40);
        n_compared++; if (out_val_q[0] !== exp_out(4194304)) begin n_failed++; $display("[TB] FAIL ext_first: got %0d, expected %0d", out_val_q[0], exp_out(4194304)); end
        n_compared++; if (out_val_q[3] !== exp_out(16777216)) begin n_failed++; $display("[TB] FAIL ext_full: got %0d, expected %0d", out_val_q[3], exp_out(16777216)); end
        n_compared++; if (out_val_q[4] !== exp_out(16777216)) begin n_failed++; $display("[TB] FAIL ext_steady: got %0d, expected %0d", out_val_q[4], exp_out(16777216)); end
    endtask

    task automatic test_coef_busy_drop();
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        clear_outputs();
        push_sample(1000);
        repeat (3) push_sample(0);
        din_valid = 1'b0;
        n_compared++; if (busy !== 1'b1) begin n_failed++; $display("[TB] FAIL drop_busy: got %b, expected 1", busy); end
        write_coef(3, 100);
        idle(1);
        wait_outputs(1, 20);
        n_compared++; if (out_val_q[0] !== exp_out(4000)) begin n_failed++; $display("[TB] FAIL drop_inflight: got %0d, expected %0d", out_val_q[0], exp_out(4000)); end
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_outputs();
        push_sample(1000);
        repeat (3) push_sample(0);
        idle(1);
        wait_outputs(1, 20);
        n_compared++; if (out_val_q[0] !== exp_out(4000)) begin n_failed++; $display("[TB] FAIL drop_readback: got %0d, expected %0d", out_val_q[0], exp_out(4000)); end
    endtask

    task automatic test_start_abort();
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, 1);
        clear_outputs();
        repeat (4) push_sample(1);
        idle(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(8);
        n_compared++; if (out_val_q.size() != 0) begin n_failed++; $display("[TB] FAIL abort_nostrobe: got %0d results, expected 0", out_val_q.size()); end
        n_compared++; if (busy !== 1'b0) begin n_failed++; $display("[TB] FAIL abort_busy: got %b, expected 0", busy); end
        repeat (3) push_sample(1);
        idle(8);
        n_compared++; if (out_val_q.size() != 0) begin n_failed++; $display("[TB] FAIL abort_early: got %0d results, expected 0", out_val_q.size()); end
        push_sample(1);
        idle(1);
        wait_outputs(1, 20);
        n_compared++; if (out_val_q[0] !== exp_out(4)) begin n_failed++; $display("[TB] FAIL abort_fresh: got %0d, expected %0d", out_val_q[0], exp_out(4)); end
    endtask

`ifdef POLYPHASE_DECIM_FIR_ROUND_SAT_EN
    task automatic test_round_sat();
        do_reset();
        write_coef(3, 4);
        clear_outputs();
        push_sample(96);
        repeat (3) push_sample(0);
        idle(1);
        wait_outputs(1, 20);
        n_compared++; if (out_val_q[0] !== 16'sd2) begin n_failed++; $display("[TB] FAIL round_half_up: got %0d, expected 2", out_val_q[0]); end
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, -1024);
        clear_outputs();
        repeat (16) push_sample(-1024);
        idle(1);
        wait_outputs(4, 40);
        n_compared++; if (out_val_q[3] !== 16'sd32767) begin n_failed++; $display("[TB] FAIL saturate: got %0d, expected 32767", out_val_q[3]); end
    endtask
`endif

    initial begin
        test_reset();
        test_impulse();
        test_dc_backpressure();
        test_extremes();
        test_coef_busy_drop();
        test_start_abort();
`ifdef POLYPHASE_DECIM_FIR_ROUND_SAT_EN
        test_round_sat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
